mem_bus_arbiter: RTL and testbench

- Shares the single memory-mapped device bus between the instruction-fetch port and the load/store data port of the RISC-V core.
- Replaces clock-phase time-multiplexing with a registered request/acknowledge handshake. Supports wait states and a bus timeout.
- Sits between the core and the memory map decoder. The decoder sees one address/strobe set at a time.

---
 rtl/mem_bus_arbiter.sv | 144 ++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - fetch/data bus arbiter with wait states and timeout abort
// Optional MEM_ARB_ROUND_ROBIN_EN alternates grants on contention; default is data-over-fetch priority.
module mem_bus_arbiter #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int WAIT_STATES = 1,
  parameter int TIMEOUT     = 15
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic [DATA_WIDTH-1:0] if_rdata,
  output logic                  if_ack,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  d_ack,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [DATA_WIDTH-1:0] bus_wdata,
  output logic                  bus_read,
  output logic                  bus_write,
  input  logic [DATA_WIDTH-1:0] bus_rdata,
  input  logic                  bus_ready,
  output logic                  bus_err
);

  typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_t;

  state_t                state, state_nx;
  logic [3:0]            wait_cnt, wait_nx;
  logic [7:0]            to_cnt, to_nx;
  logic                  grant_d, grant_d_nx;
  logic                  pick_d;
  logic [ADDR_WIDTH-1:0] addr_nx;
  logic [DATA_WIDTH-1:0] wdata_nx, if_rdata_nx, d_rdata_nx;
  logic                  read_nx, write_nx, if_ack_nx, d_ack_nx, err_nx;
`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic                  last_grant, last_nx;  // 0 = fetch, 1 = data

  assign pick_d = d_req && (!if_req || !last_grant);
`else
  assign pick_d = d_req;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      to_cnt    <= '0;
      grant_d   <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      bus_read  <= 1'b0;
      bus_write <= 1'b0;
      if_rdata  <= '0;
      d_rdata   <= '0;
      if_ack    <= 1'b0;
      d_ack     <= 1'b0;
      bus_err   <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_grant <= 1'b0;
`endif
    end else begin
      state     <= state_nx;
      wait_cnt  <= wait_nx;
      to_cnt    <= to_nx;
      grant_d   <= grant_d_nx;
      bus_addr  <= addr_nx;
      bus_wdata <= wdata_nx;
      bus_read  <= read_nx;
      bus_write <= write_nx;
      if_rdata  <= if_rdata_nx;
      d_rdata   <= d_rdata_nx;
      if_ack    <= if_ack_nx;
      d_ack     <= d_ack_nx;
      bus_err   <= err_nx;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_grant <= last_nx;
`endif
    end
  end

  always_comb begin
    state_nx    = state;
    wait_nx     = wait_cnt;
    to_nx       = to_cnt;
    grant_d_nx  = grant_d;
    addr_nx     = bus_addr;
    wdata_nx    = bus_wdata;
    read_nx     = bus_read;
    write_nx    = bus_write;
    if_rdata_nx = if_rdata;
    d_rdata_nx  = d_rdata;
    if_ack_nx   = 1'b0;
    d_ack_nx    = 1'b0;
    err_nx      = 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    last_nx     = last_grant;
`endif
    case (state)
      IDLE: begin
        if (if_req || d_req) begin
          state_nx   = ACCESS;
          grant_d_nx = pick_d;
          addr_nx    = pick_d ? d_addr : if_addr;
          wdata_nx   = pick_d ? d_wdata : '0;
          read_nx    = !(pick_d && d_we);
          write_nx   = pick_d && d_we;
          wait_nx    = 4'(WAIT_STATES);
          to_nx      = 8'(TIMEOUT);
`ifdef MEM_ARB_ROUND_ROBIN_EN
          last_nx    = pick_d;
`endif
        end
      end
      ACCESS: begin
        if (wait_cnt != 4'd0) begin
          wait_nx = wait_cnt - 4'd1;
        end else if (bus_ready || (to_cnt == 8'd0)) begin
          // Completion and timeout abort share one exit; a late ready still wins.
          state_nx = ACK;
          read_nx  = 1'b0;
          write_nx = 1'b0;
          err_nx   = !bus_ready;
          if (grant_d) begin
            d_ack_nx   = 1'b1;
            d_rdata_nx = (bus_ready && !bus_write) ? bus_rdata : '0;
          end else begin
            if_ack_nx   = 1'b1;
            if_rdata_nx = bus_ready ? bus_rdata : '0;
          end
        end else begin
          to_nx = to_cnt - 8'd1;
        end
      end
      ACK:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - self-checking bench for mem_bus_arbiter
// Three instances (WAIT_STATES 0, 2, 1; TIMEOUT 15) share the clock and reset.
module tb_mem_bus_arbiter;

  localparam int N  = 3;
  localparam int TO = 15;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        if_req    [N];
  logic [31:0] if_addr   [N];
  logic [31:0] if_rdata  [N];
  logic        if_ack    [N];
  logic        d_req     [N];
  logic        d_we      [N];
  logic [31:0] d_addr    [N];
  logic [31:0] d_wdata   [N];
  logic [31:0] d_rdata   [N];
  logic        d_ack     [N];
  logic [31:0] bus_addr  [N];
  logic [31:0] bus_wdata [N];
  logic        bus_read  [N];
  logic        bus_write [N];
  logic [31:0] bus_rdata [N];
  logic        bus_ready [N];
  logic        bus_err   [N];

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    mem_bus_arbiter #(
      .ADDR_WIDTH (32),
      .DATA_WIDTH (32),
      .WAIT_STATES((g == 0) ? 0 : ((g == 1) ? 2 : 1)),
      .TIMEOUT    (TO)
    ) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .if_req   (if_req[g]),
      .if_addr  (if_addr[g]),
      .if_rdata (if_rdata[g]),
      .if_ack   (if_ack[g]),
      .d_req    (d_req[g]),
      .d_we     (d_we[g]),
      .d_addr   (d_addr[g]),
      .d_wdata  (d_wdata[g]),
      .d_rdata  (d_rdata[g]),
      .d_ack    (d_ack[g]),
      .bus_addr (bus_addr[g]),
      .bus_wdata(bus_wdata[g]),
      .bus_read (bus_read[g]),
      .bus_write(bus_write[g]),
      .bus_rdata(bus_rdata[g]),
      .bus_ready(bus_ready[g]),
      .bus_err  (bus_err[g])
    );
  end

  function automatic int ws_of(input int i);
    return (i == 0) ? 0 : ((i == 1) ? 2 : 1);
  endfunction

  // Transaction-level reference: each access is timed by counting edges since its grant.
  int          k;
  bit          m_busy [N];
  bit          m_ackc [N];
  int          m_g    [N];
  bit          m_d    [N];
  bit          m_we   [N];
  logic [31:0] e_addr [N];
  logic [31:0] e_wdata[N];
  logic [31:0] e_ifr  [N];
  logic [31:0] e_dr   [N];
  bit          e_rd   [N];
  bit          e_wr   [N];
  bit          e_ifa  [N];
  bit          e_da   [N];
  bit          e_err  [N];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k <= 0;
      for (int i = 0; i < N; i++) begin
        m_busy[i] <= 1'b0; m_ackc[i] <= 1'b0; m_g[i] <= 0; m_d[i] <= 1'b0; m_we[i] <= 1'b0;
        e_addr[i] <= '0; e_wdata[i] <= '0; e_ifr[i] <= '0; e_dr[i] <= '0;
        e_rd[i] <= 1'b0; e_wr[i] <= 1'b0; e_ifa[i] <= 1'b0; e_da[i] <= 1'b0; e_err[i] <= 1'b0;
      end
    end else begin
      k <= k + 1;
      for (int i = 0; i < N; i++) begin
        if (m_ackc[i]) begin
          m_ackc[i] <= 1'b0;
          e_ifa[i]  <= 1'b0;
          e_da[i]   <= 1'b0;
          e_err[i]  <= 1'b0;
        end else if (m_busy[i]) begin
          if ((k - m_g[i] >= 1 + ws_of(i)) &&
              (bus_ready[i] || (k - m_g[i] == 1 + ws_of(i) + TO))) begin
            m_busy[i] <= 1'b0;
            m_ackc[i] <= 1'b1;
            e_rd[i]   <= 1'b0;
            e_wr[i]   <= 1'b0;
            e_err[i]  <= !bus_ready[i];
            if (m_d[i]) begin
              e_da[i] <= 1'b1;
              e_dr[i] <= (bus_ready[i] && !m_we[i]) ? bus_rdata[i] : 32'h0;
            end else begin
              e_ifa[i] <= 1'b1;
              e_ifr[i] <= bus_ready[i] ? bus_rdata[i] : 32'h0;
            end
          end
        end else if (if_req[i] || d_req[i]) begin
          m_busy[i]  <= 1'b1;
          m_g[i]     <= k;
          m_d[i]     <= d_req[i];
          m_we[i]    <= d_req[i] && d_we[i];
          e_addr[i]  <= d_req[i] ? d_addr[i] : if_addr[i];
          e_wdata[i] <= d_req[i] ? d_wdata[i] : 32'h0;
          e_rd[i]    <= !(d_req[i] && d_we[i]);
          e_wr[i]    <= d_req[i] && d_we[i];
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < N; i++) begin
      chk($sformatf("inst%0d bus_read", i),  32'(bus_read[i]),  32'(e_rd[i]));
      chk($sformatf("inst%0d bus_write", i), 32'(bus_write[i]), 32'(e_wr[i]));
      chk($sformatf("inst%0d if_ack", i),    32'(if_ack[i]),    32'(e_ifa[i]));
      chk($sformatf("inst%0d d_ack", i),     32'(d_ack[i]),     32'(e_da[i]));
      chk($sformatf("inst%0d bus_err", i),   32'(bus_err[i]),   32'(e_err[i]));
      if (e_rd[i] || e_wr[i]) chk($sformatf("inst%0d bus_addr", i), bus_addr[i], e_addr[i]);
      if (e_wr[i]) chk($sformatf("inst%0d bus_wdata", i), bus_wdata[i], e_wdata[i]);
      if (e_ifa[i]) chk($sformatf("inst%0d if_rdata", i), if_rdata[i], e_ifr[i]);
      if (e_da[i]) chk($sformatf("inst%0d d_rdata", i), d_rdata[i], e_dr[i]);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    check_all();
  endtask

  typedef struct {
    int          inst;
    bit          is_d;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    bit          ready;
    int          exp_cyc;
    bit          exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  task automatic run_vec(input int idx, input vec_t v);
    int          cnt = 0;
    bit          got = 0;
    bit          saw_wr = 0;
    logic [31:0] saw_addr = '0;
    logic [31:0] saw_wd = '0;
    int          n = v.inst;
    bus_ready[n] = v.ready;
    bus_rdata[n] = v.rdata;
    if (v.is_d) begin
      d_req[n] = 1'b1; d_we[n] = v.we; d_addr[n] = v.addr; d_wdata[n] = v.wdata;
    end else begin
      if_req[n] = 1'b1; if_addr[n] = v.addr;
    end
    for (int c = 0; c < 60 && !got; c++) begin
      tick();
      if (bus_read[n] || bus_write[n]) begin
        cnt++; saw_addr = bus_addr[n]; saw_wr = bus_write[n]; saw_wd = bus_wdata[n];
      end
      if (if_ack[n] || d_ack[n]) begin
        got = 1;
        chk($sformatf("vec%0d ack port", idx), 32'(d_ack[n]), 32'(v.is_d));
        chk($sformatf("vec%0d rdata", idx), v.is_d ? d_rdata[n] : if_rdata[n], v.exp_rdata);
        chk($sformatf("vec%0d bus_err", idx), 32'(bus_err[n]), 32'(v.exp_err));
      end
    end
    chk($sformatf("vec%0d ack seen", idx), 32'(got), 32'd1);
    chk($sformatf("vec%0d strobe cycles", idx), 32'(cnt), 32'(v.exp_cyc));
    chk($sformatf("vec%0d bus_addr", idx), saw_addr, v.addr);
    chk($sformatf("vec%0d write strobe", idx), 32'(saw_wr), 32'(v.is_d && v.we));
    if (v.is_d && v.we) chk($sformatf("vec%0d bus_wdata", idx), saw_wd, v.wdata);
    d_req[n] = 1'b0;
    if_req[n] = 1'b0;
    tick();
    tick();
  endtask

  vec_t vecs [8];
  int   stall [N];

  initial begin
    int c_d, c_if;
    bit first_d;
    logic [31:0] first_addr;
    bit seen_strobe;

    for (int i = 0; i < N; i++) begin
      if_req[i] = 0; if_addr[i] = 0; d_req[i] = 0; d_we[i] = 0; d_addr[i] = 0;
      d_wdata[i] = 0; bus_rdata[i] = 0; bus_ready[i] = 0; stall[i] = 0;
    end

    vecs[0] = '{0, 0, 0, 32'h0040_0004, 32'h0,         32'h0000_0013, 1, 1,  0, 32'h0000_0013};
    vecs[1] = '{1, 1, 1, 32'h1001_0024, 32'hDEAD_BEEF, 32'h55AA_55AA, 1, 3,  0, 32'h0};
    vecs[2] = '{2, 1, 0, 32'h1001_0040, 32'h0,         32'h1234_5678, 0, 17, 1, 32'h0};
    vecs[3] = '{0, 1, 0, 32'h0000_0080, 32'h0,         32'hCAFE_F00D, 1, 1,  0, 32'hCAFE_F00D};
    vecs[4] = '{2, 0, 0, 32'h0040_0100, 32'h0,         32'h00A0_0093, 1, 2,  0, 32'h00A0_0093};
    vecs[5] = '{0, 1, 1, 32'h1001_0000, 32'h1111_2222, 32'h9999_9999, 0, 16, 1, 32'h0};
    vecs[6] = '{1, 0, 0, 32'h0040_0008, 32'h0,         32'hFFFF_FFFF, 1, 3,  0, 32'hFFFF_FFFF};
    vecs[7] = '{1, 0, 0, 32'h0040_000C, 32'h0,         32'h7777_7777, 0, 18, 1, 32'h0};

    tick();
    tick();
    chk("reset bus_addr", bus_addr[0], 32'h0);
    chk("reset bus_wdata", bus_wdata[0], 32'h0);
    chk("reset if_rdata", if_rdata[0], 32'h0);
    chk("reset d_rdata", d_rdata[0], 32'h0);
    chk("reset strobes", 32'({bus_read[0], bus_write[0], if_ack[0], d_ack[0], bus_err[0]}), 32'h0);
    rst_n = 1'b1;
    tick();

    foreach (vecs[v]) run_vec(v, vecs[v]);

    // Simultaneous requests: data wins, fetch follows three cycles after d_ack.
    c_d = -1; c_if = -1; first_d = 0; seen_strobe = 0; first_addr = '0;
    bus_ready[0] = 1; bus_rdata[0] = 32'h0BAD_F00D;
    if_req[0] = 1; if_addr[0] = 32'h0040_0020;
    d_req[0] = 1; d_we[0] = 0; d_addr[0] = 32'h1001_0008;
    for (int c = 0; c < 40 && c_if < 0; c++) begin
      tick();
      if (!seen_strobe && bus_read[0]) begin seen_strobe = 1; first_addr = bus_addr[0]; end
      if (d_ack[0]) begin c_d = c; if (c_if < 0) first_d = 1; d_req[0] = 0; end
      if (if_ack[0]) begin c_if = c; if_req[0] = 0; end
    end
    chk("contend data first", 32'(first_d), 32'd1);
    chk("contend first addr", first_addr, 32'h1001_0008);
    chk("contend fetch ack seen", 32'(c_if >= 0), 32'd1);
    chk("contend ack spacing", 32'(c_if - c_d), 32'd3);
    if_req[0] = 0; d_req[0] = 0;
    tick();

    // Reset during the second ACCESS cycle, then a clean fetch.
    bus_ready[2] = 0; d_req[2] = 1; d_we[2] = 0; d_addr[2] = 32'h1001_0100;
    tick();
    tick();
    chk("pre-reset strobe", 32'(bus_read[2]), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async reset bus_read", 32'(bus_read[2]), 32'd0);
    chk("async reset bus_write", 32'(bus_write[2]), 32'd0);
    chk("async reset acks", 32'({if_ack[2], d_ack[2], bus_err[2]}), 32'd0);
    d_req[2] = 0;
    tick();
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 25; c++) begin
      tick();
      chk("no ack after abort", 32'({d_ack[2], if_ack[2]}), 32'd0);
    end
    run_vec(8, '{2, 0, 0, 32'h0040_0200, 32'h0, 32'h0000_0297, 1, 2, 0, 32'h0000_0297});

    // Randomized requesters on all instances, checked cycle by cycle against the model.
    for (int c = 0; c < 3000; c++) begin
      tick();
      for (int i = 0; i < N; i++) begin
        bus_rdata[i] = $urandom;
        if (stall[i] > 0) begin
          stall[i]--; bus_ready[i] = 0;
        end else if ($urandom_range(0, 99) < 2) begin
          stall[i] = 20; bus_ready[i] = 0;
        end else begin
          bus_ready[i] = ($urandom_range(0, 99) < 80);
        end
        if (!if_req[i] || if_ack[i]) begin
          if_req[i] = ($urandom_range(0, 2) == 0);
          if_addr[i] = $urandom & 32'hFFFF_FFFC;
        end
        if (!d_req[i] || d_ack[i]) begin
          d_req[i] = ($urandom_range(0, 2) == 0);
          d_we[i] = $urandom_range(0, 1);
          d_addr[i] = $urandom;
          d_wdata[i] = $urandom;
        end
      end
    end
    for (int i = 0; i < N; i++) begin if_req[i] = 0; d_req[i] = 0; end
    for (int c = 0; c < 80; c++) begin
      tick();
      for (int i = 0; i < N; i++) begin
        if (if_ack[i]) if_req[i] = 0;
        if (d_ack[i]) d_req[i] = 0;
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
